leds_ctrl: RTL and testbench



---
 rtl/leds_ctrl.sv | 93 +++++++++
 tb/tb_leds_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/leds_ctrl.sv
// Two-channel pushbutton front end: 2-flop synchroniser, debounce and LED drive per button.
// Optional LEDS_TOGGLE_EN: each accepted press toggles its LED instead of mirroring the button.
module leds_ctrl #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter bit LED_INVERT      = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] but,
  output logic [1:0] led
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0] lit;

  for (genvar i = 0; i < 2; i++) begin : g_chan
    logic          s1;
    logic          s2;
    logic          db;
    logic          lit_q;
    logic [CW-1:0] cnt;
    logic          db_nxt;
    logic [CW-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= but[i];
        s2 <= s1;
      end
    end

    // A level must sit at s2 for DEBOUNCE_CYCLES consecutive cycles; any
    // return to the debounced value discards the partial count.
    always_comb begin
      db_nxt  = db;
      cnt_nxt = cnt;
      if (s2 == db) begin
        cnt_nxt = '0;
      end else if (cnt == CNT_MAX) begin
        db_nxt  = s2;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db  <= 1'b0;
        cnt <= '0;
      end else begin
        db  <= db_nxt;
        cnt <= cnt_nxt;
      end
    end

`ifdef LEDS_TOGGLE_EN
    logic db_q;

    // db_q lags db by one cycle, so the toggle lands one edge after db rises.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_q  <= 1'b0;
        lit_q <= 1'b0;
      end else begin
        db_q <= db;
        if (db && !db_q) begin
          lit_q <= ~lit_q;
        end
      end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lit_q <= 1'b0;
      end else begin
        lit_q <= db;
      end
    end
`endif

    assign lit[i] = lit_q;
  end

  // Inversion is a constant XOR on the register output, so led stays glitch-free.
  assign led = lit ^ {2{LED_INVERT}};

endmodule

// File: tb/tb_leds_ctrl.sv
// Scoreboard bench for leds_ctrl: stimulus queues timed expectations, a negedge monitor checks them.
// Covers mirror mode by default and toggle mode when LEDS_TOGGLE_EN is defined.
module tb_leds_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] but;
  logic [1:0] led;
  logic [1:0] led_inv;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  typedef struct {
    int         cyc;
    logic [1:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];

  leds_ctrl #(.DEBOUNCE_CYCLES(2), .LED_INVERT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .but(but), .led(led)
  );

  leds_ctrl #(.DEBOUNCE_CYCLES(2), .LED_INVERT(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .but(but), .led(led_inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  // Expected values are logical LED states; the inverted instance must show their complement.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == edges) begin
        checks++;
        if (led !== sb[i].val) begin
          errors++;
          $display("FAIL %s @edge %0d: led=%b expected %b", sb[i].name, edges, led, sb[i].val);
        end
        checks++;
        if (led_inv !== ~sb[i].val) begin
          errors++;
          $display("FAIL %s_inv @edge %0d: led=%b expected %b", sb[i].name, edges, led_inv, ~sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].cyc < edges) begin
        checks++;
        errors++;
        $display("FAIL %s missed check for edge %0d (now %0d)", sb[i].name, sb[i].cyc, edges);
        sb.delete(i);
      end
    end
  end

  task automatic push(input int cyc, input logic [1:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drive a new button value and expect the LED to change exactly 5 edges later.
  task automatic chg(input logic [1:0] b, input logic [1:0] old_v, input logic [1:0] new_v,
                     input string nm);
    int e;
    e   = edges;
    but = b;
    push(e + 4, old_v, {nm, "_hold"});
    push(e + 5, new_v, nm);
  endtask

  initial begin
    int e;
    rst_n = 1'b0;
    but   = 2'b11;
    tick(1);
    e = edges;
    push(e + 1, 2'b00, "rst_held_a");
    push(e + 2, 2'b00, "rst_held_b");
    tick(4);
    rst_n = 1'b1;
    e = edges;
    push(e + 4, 2'b00, "rst_rel_hold");
    push(e + 5, 2'b11, "rst_rel");
    tick(10);

`ifdef LEDS_TOGGLE_EN
    chg(2'b00, 2'b11, 2'b11, "tog_release_noop");
    tick(10);
    rst_n = 1'b0;
    push(edges, 2'b00, "tog_rst_clear");
    tick(3);
    rst_n = 1'b1;
    tick(10);
    push(edges + 1, 2'b00, "tog_idle");
    chg(2'b01, 2'b00, 2'b01, "tog_press1");
    tick(10);
    chg(2'b00, 2'b01, 2'b01, "tog_release1");
    tick(10);
    chg(2'b01, 2'b01, 2'b00, "tog_press2");
    tick(10);
    chg(2'b00, 2'b00, 2'b00, "tog_release2");
    tick(10);
`else
    chg(2'b00, 2'b11, 2'b00, "seq_0");
    tick(5);
    chg(2'b01, 2'b00, 2'b01, "seq_1");
    tick(5);
    chg(2'b10, 2'b01, 2'b10, "seq_2");
    tick(5);
    chg(2'b11, 2'b10, 2'b11, "seq_3");
    tick(10);
    chg(2'b00, 2'b11, 2'b00, "settle_0");
    tick(10);

    e   = edges;
    but = 2'b01;
    tick(1);
    but = 2'b00;
    for (int k = 3; k <= 8; k++) push(e + k, 2'b00, "glitch_1cyc");
    tick(10);

    e   = edges;
    but = 2'b01;
    tick(2);
    but = 2'b00;
    push(e + 4, 2'b00, "pulse2_pre");
    push(e + 5, 2'b01, "pulse2_on");
    push(e + 6, 2'b01, "pulse2_hold");
    push(e + 7, 2'b00, "pulse2_off");
    tick(10);

    e   = edges;
    but = 2'b01;
    tick(3);
    but = 2'b00;
    push(e + 4, 2'b00, "pulse3_pre");
    push(e + 5, 2'b01, "pulse3_on");
    push(e + 7, 2'b01, "pulse3_hold");
    push(e + 8, 2'b00, "pulse3_off");
    tick(10);

    chg(2'b11, 2'b00, 2'b11, "lit_3");
    tick(8);
    rst_n = 1'b0;
    push(edges, 2'b00, "rst_lit_off");
    tick(2);
    rst_n = 1'b1;
    e = edges;
    push(e + 4, 2'b00, "rst_lit_rel_hold");
    push(e + 5, 2'b11, "rst_lit_rel");
    tick(10);

    chg(2'b00, 2'b11, 2'b00, "pre_mid_0");
    tick(10);
    but = 2'b11;
    tick(2);
    rst_n = 1'b0;
    push(edges, 2'b00, "mid_rst_off");
    tick(3);
    rst_n = 1'b1;
    e = edges;
    push(e + 4, 2'b00, "mid_rel_hold");
    push(e + 5, 2'b11, "mid_rel");
    tick(10);
`endif

    for (int t = 0; t < 200 && sb.size() != 0; t++) tick(1);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
